// File: rtl/multi_req_ack_if.sv
// Handshake bundle for multi_req_ack: per-channel request/ack plus status.
// The master drives requests and err_clr; the slave answers with ack/full/drop_err/busy.
interface multi_req_ack_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] req;
  logic            err_clr;
  logic [N_CH-1:0] ack;
  logic [N_CH-1:0] full;
  logic [N_CH-1:0] drop_err;
  logic            busy;

  modport master (output req, err_clr, input  ack, full, drop_err, busy);
  modport slave  (input  req, err_clr, output ack, full, drop_err, busy);
endinterface

// File: rtl/multi_req_ack.sv
// Multi-channel req/ack responder: per-channel pending counters, round-robin
// grant of one channel per cycle, ACK_LAT-deep ack pipeline, overflow reporting.

// Per-channel pending counter with accept/drop decision and sticky drop flag.
module mra_chan #(
  parameter int PEND_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_gnt,
  input  logic i_err_clr,
  output logic o_pend,
  output logic o_full,
  output logic o_drop_err
);
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [PEND_W-1:0] r_cnt;
  logic [PEND_W-1:0] w_cnt_nxt;
  logic              r_full;
  logic              r_drop_err;
  logic              w_at_max;
  logic              w_acc;
  logic              w_drop;

  // A request arriving at PMAX still fits if this channel drains in the same cycle.
  assign w_at_max = (r_cnt == PMAX);
  assign w_acc    = i_req & (~w_at_max | i_gnt);
  assign w_drop   = i_req & w_at_max & ~i_gnt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_acc && !i_gnt)      w_cnt_nxt = r_cnt + PEND_W'(1);
    else if (!w_acc && i_gnt) w_cnt_nxt = r_cnt - PEND_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_drop_err <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == PMAX);
      if (w_drop)         r_drop_err <= 1'b1;
      else if (i_err_clr) r_drop_err <= 1'b0;
    end
  end

  assign o_pend     = |r_cnt;
  assign o_full     = r_full;
  assign o_drop_err = r_drop_err;
endmodule

module multi_req_ack #(
  parameter int N_CH    = 4,
  parameter int ACK_LAT = 1,
  parameter int PEND_W  = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  multi_req_ack_if.slave bus
);
  localparam int             PW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PW-1:0]  PTR_RST = PW'(N_CH - 1);

  logic [N_CH-1:0]               w_pend;
  logic [N_CH-1:0]               w_gnt;
  logic                          w_any;
  logic                          w_any_hi;
  logic [PW-1:0]                 w_hi;
  logic [PW-1:0]                 w_lo;
  logic [PW-1:0]                 w_win;
  logic [PW-1:0]                 r_ptr;
  logic [ACK_LAT-1:0][N_CH-1:0]  r_stage;
  logic [ACK_LAT-1:0]            r_vld_pipe;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    mra_chan #(.PEND_W(PEND_W)) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_req      (bus.req[gi]),
      .i_gnt      (w_gnt[gi]),
      .i_err_clr  (bus.err_clr),
      .o_pend     (w_pend[gi]),
      .o_full     (bus.full[gi]),
      .o_drop_err (bus.drop_err[gi])
    );
  end

  // Round-robin: lowest pending channel above r_ptr, else lowest pending overall.
  always_comb begin
    w_any    = 1'b0;
    w_any_hi = 1'b0;
    w_hi     = '0;
    w_lo     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (w_pend[i]) begin
        w_any = 1'b1;
        w_lo  = PW'(i);
        if (PW'(i) > r_ptr) begin
          w_any_hi = 1'b1;
          w_hi     = PW'(i);
        end
      end
    end
    w_win = w_any_hi ? w_hi : w_lo;
    w_gnt = w_any ? (N_CH'(1) << w_win) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= PTR_RST;
      r_stage    <= '0;
      r_vld_pipe <= '0;
    end else begin
      if (w_any) r_ptr <= w_win;
      r_stage[0]    <= w_gnt;
      r_vld_pipe[0] <= w_any;
      for (int s = 1; s < ACK_LAT; s++) begin
        r_stage[s]    <= r_stage[s-1];
        r_vld_pipe[s] <= r_vld_pipe[s-1];
      end
    end
  end

  assign bus.ack  = r_stage[ACK_LAT-1];
  assign bus.busy = (|w_pend) | (|r_vld_pipe);
endmodule

// File: tb/tb_multi_req_ack.sv
// Bench for multi_req_ack: two instances (ACK_LAT=1 and 3) share stimulus; an
// abstract per-channel model is compared every cycle, plus directed literal checks.
module tb_multi_req_ack;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tb_req = '0;
  logic       tb_clr = 1'b0;

  always #5 clk = ~clk;

  multi_req_ack_if #(.N_CH(4)) bif0 ();
  multi_req_ack_if #(.N_CH(4)) bif1 ();
  assign bif0.req = tb_req;  assign bif0.err_clr = tb_clr;
  assign bif1.req = tb_req;  assign bif1.err_clr = tb_clr;

  multi_req_ack #(.N_CH(4), .ACK_LAT(1), .PEND_W(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bif0));
  multi_req_ack #(.N_CH(4), .ACK_LAT(3), .PEND_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bif1));

  logic [3:0] gack[2], gfull[2], gdrop[2];
  logic       gbusy[2];
  assign gack[0] = bif0.ack;  assign gfull[0] = bif0.full;  assign gdrop[0] = bif0.drop_err;  assign gbusy[0] = bif0.busy;
  assign gack[1] = bif1.ack;  assign gfull[1] = bif1.full;  assign gdrop[1] = bif1.drop_err;  assign gbusy[1] = bif1.busy;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- abstract model ----------------
  int         cnt[2][4];
  int         ptr[2];
  logic [3:0] derr[2];
  logic [3:0] sched[2][8192];   // expected ack vector indexed by cycle number
  int         lat[2] = '{1, 3};
  int         cyc = 0;

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) cnt[d][i] = 0;
      ptr[d]  = 3;
      derr[d] = '0;
      for (int j = 0; j <= 4; j++) sched[d][(cyc + j) % 8192] = '0;
    end
  endtask

  task automatic m_step(int d);
    int g;
    int idx;
    bit acc;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      idx = (ptr[d] + k) % 4;
      if (g < 0 && cnt[d][idx] > 0) g = idx;
    end
    if (g >= 0) begin
      sched[d][(cyc + lat[d]) % 8192][g] = 1'b1;
      ptr[d] = g;
    end
    for (int i = 0; i < 4; i++) begin
      acc = tb_req[i] && (cnt[d][i] < 3 || g == i);
      if (tb_req[i] && !acc) derr[d][i] = 1'b1;
      else if (tb_clr)       derr[d][i] = 1'b0;
      cnt[d][i] = cnt[d][i] + (acc ? 1 : 0) - ((g == i) ? 1 : 0);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      m_step(0);
      m_step(1);
    end
    cyc++;
  end

  always @(negedge rst_n) m_reset();

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [3:0] efull;
    logic       ebusy;
    for (int d = 0; d < 2; d++) begin
      efull = '0;
      ebusy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        efull[i] = (cnt[d][i] == 3);
        if (cnt[d][i] != 0) ebusy = 1'b1;
      end
      for (int j = 0; j < lat[d]; j++) if (sched[d][(cyc + j) % 8192] != 0) ebusy = 1'b1;
      chk($sformatf("model ack d%0d", d),  gack[d],  sched[d][cyc % 8192]);
      chk($sformatf("model full d%0d", d), gfull[d], efull);
      chk($sformatf("model drop d%0d", d), gdrop[d], derr[d]);
      chk($sformatf("model busy d%0d", d), gbusy[d], ebusy);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick(); #1; rst_n = 1'b0; tb_req = '0; tb_clr = 1'b0;
    tick(); #1; rst_n = 1'b1;
  endtask

  int a0[4], a1[4];

  initial begin
    for (int d = 0; d < 2; d++) for (int j = 0; j < 8192; j++) sched[d][j] = '0;
    m_reset();
    tick();
    chk("reset ack",  gack[0],  4'h0);
    chk("reset full", gfull[0], 4'h0);
    chk("reset drop", gdrop[0], 4'h0);
    chk("reset busy", gbusy[0], 1'b0);
    tick(); tick(); #1; rst_n = 1'b1;
    tick(); tick();

    // single pulse on ch0
    #1 tb_req = 4'b0001;
    tick(); chk("t1 ack c+1", gack[0], 4'h0); chk("t1 busy c+1", gbusy[0], 1'b1); #1 tb_req = '0;
    tick(); chk("t1 ack c+2", gack[0], 4'b0001); chk("t1 busy c+2", gbusy[0], 1'b1); chk("t1 drop", gdrop[0], 4'h0);
    tick(); chk("t1 ack c+3", gack[0], 4'h0); chk("t1 busy c+3", gbusy[0], 1'b0); chk("t1 lat3 ack c+3", gack[1], 4'h0);
    tick(); chk("t1 lat3 ack c+4", gack[1], 4'b0001);
    tick(); chk("t1 lat3 ack c+5", gack[1], 4'h0);

    // contention: all four channels for one cycle
    do_reset();
    tick(); #1 tb_req = 4'b1111;
    tick(); #1 tb_req = '0;
    tick(); chk("t2 ack c+2", gack[0], 4'b0001);
    tick(); chk("t2 ack c+3", gack[0], 4'b0010);
    tick(); chk("t2 ack c+4", gack[0], 4'b0100); chk("t2 lat3 c+4", gack[1], 4'b0001);
    tick(); chk("t2 ack c+5", gack[0], 4'b1000); chk("t2 lat3 c+5", gack[1], 4'b0010);
    tick(); chk("t2 ack c+6", gack[0], 4'h0);

    // overflow: all four held for four cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin a0[i] = 0; a1[i] = 0; end
    tick(); #1 tb_req = 4'b1111;
    for (int t = 1; t <= 34; t++) begin
      tick();
      for (int i = 0; i < 4; i++) begin a0[i] += gack[0][i]; a1[i] += gack[1][i]; end
      if (t == 3) chk("t3 full c+3", gfull[0], 4'b1100);
      if (t == 4) begin
        chk("t3 drop c+4", gdrop[0], 4'b1000);
        chk("t3 lat3 drop c+4", gdrop[1], 4'b1000);
        chk("t3 full c+4", gfull[0], 4'b1111);
      end
      if (t == 34) chk("t3 drop sticky", gdrop[0], 4'b1000);
      #1 tb_req = (t <= 3) ? 4'b1111 : 4'b0000;
    end
    chk("t3 acks ch0", a0[0], 4); chk("t3 acks ch1", a0[1], 4);
    chk("t3 acks ch2", a0[2], 4); chk("t3 acks ch3", a0[3], 3);
    chk("t3 lat3 acks ch0", a1[0], 4); chk("t3 lat3 acks ch3", a1[3], 3);
    tb_clr = 1'b1;
    tick(); chk("t3 err_clr", gdrop[0], 4'h0); #1 tb_clr = 1'b0;

    // latency: single pulse then 3-cycle burst on ch1
    do_reset();
    tick(); #1 tb_req = 4'b0010;
    for (int t = 1; t <= 6; t++) begin
      tick();
      chk("t4 lat3 single", gack[1], (t == 4) ? 4'b0010 : 4'b0000);
      #1 tb_req = '0;
    end
    do_reset();
    tick(); #1 tb_req = 4'b0010;
    for (int t = 1; t <= 8; t++) begin
      tick();
      chk("t4 lat3 burst", gack[1], (t >= 4 && t <= 6) ? 4'b0010 : 4'b0000);
      chk("t4 lat1 burst", gack[0], (t >= 2 && t <= 4) ? 4'b0010 : 4'b0000);
      #1 tb_req = (t <= 2) ? 4'b0010 : 4'b0000;
    end

    // reset mid-operation
    do_reset();
    tick(); #1 tb_req = 4'b1111;
    tick(); #1 tb_req = '0;
    tick(); chk("t5 pre-reset ack", gack[0], 4'b0001); #1 rst_n = 1'b0;
    tick(); chk("t5 in-reset busy", gbusy[0], 1'b0); chk("t5 in-reset full", gfull[0], 4'h0); #1 rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("t5 post ack", gack[0], 4'h0); chk("t5 post busy", gbusy[0], 1'b0); chk("t5 post lat3 ack", gack[1], 4'h0);
    end
    #1 tb_req = 4'b0001;
    tick(); #1 tb_req = '0;
    tick(); chk("t5 new req ack", gack[0], 4'b0001);

    // drop and err_clr in the same cycle
    do_reset();
    tick(); #1 tb_req = 4'b1111;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (t == 4) begin
        chk("t6 set-dominant", gdrop[0], 4'b1000);
        chk("t6 lat3 set-dominant", gdrop[1], 4'b1000);
      end
      #1 tb_req = (t <= 3) ? 4'b1111 : 4'b0000;
      tb_clr = (t == 3);
    end
    tb_clr = 1'b0;
    repeat (25) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
